// File: rtl/rv32i_rom_cache_ctrl_if.sv
// Bus bundle between the fetch stage, the instruction cache controller and the
// instruction ROM/bridge memory.
//   slave  : the cache controller (answers fetches, issues fills)
//   master : the environment around it (fetch stage plus backing memory)
interface rv32i_rom_cache_ctrl_if;
  // Fetch side
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        busy;
  // Fill side
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req,
    input  cpu_addr,
    output cpu_ready,
    output cpu_rdata,
    output busy,
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport master (
    output cpu_req,
    output cpu_addr,
    input  cpu_ready,
    input  cpu_rdata,
    input  busy,
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/rv32i_rom_cache_ctrl.sv
// Direct-mapped, read-only instruction cache controller with one-word lines.
// Hits are answered from local storage in the LOOKUP cycle; misses run a
// single-outstanding fill to the backing memory and answer in RESP.
// A flush invalidates every line in the cycle it is sampled; a flush seen while
// a fill is outstanding still returns the word but keeps it out of the cache.
module rv32i_rom_cache_ctrl #(
  parameter int unsigned INDEX_W = 5,
  parameter int unsigned TAG_W   = 32 - INDEX_W - 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  rv32i_rom_cache_ctrl_if.slave  bus,
  input  logic                   flush,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic [CNT_W-1:0]       miss_cnt
);

  localparam int unsigned Lines = 2 ** INDEX_W;

  // Packed cache key: fetch address split into tag / index / byte offset.
  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [1:0]         offset;
  } cache_key_t;

  // Packed cache entry as seen by the lookup and fill paths.
  typedef struct packed {
    logic             isvalid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } cache_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StFill,
    StResp
  } state_e;

  state_e             state_q, state_d;
  cache_key_t         key_q, key_d;
  logic [Lines-1:0]   valid_q, valid_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        fill_data_q, fill_data_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic               flush_pend_q, flush_pend_d;

  // Tag and data storage carry no reset; only the valid bits do.
  logic [TAG_W-1:0]   tag_mem  [Lines];
  logic [31:0]        data_mem [Lines];

  cache_entry_t       lookup_entry;
  cache_entry_t       fill_entry;
  logic               lookup_hit;
  logic               fill_we;
  logic               cpu_ready;
  logic [31:0]        cpu_rdata;

  // Entry addressed by the latched key, and the entry a fill would install.
  always_comb begin
    lookup_entry = '{
      isvalid: valid_q[key_q.index],
      tag:     tag_mem[key_q.index],
      data:    data_mem[key_q.index]
    };
    fill_entry = '{
      isvalid: 1'b1,
      tag:     key_q.tag,
      data:    bus.mem_rdata
    };
    // A flush sampled during the lookup forces a miss.
    lookup_hit = lookup_entry.isvalid && (lookup_entry.tag == key_q.tag) && !flush;
  end

  // Next-state, datapath updates and CPU-side outputs.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    valid_d      = valid_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fill_data_d  = fill_data_q;
    rdata_d      = rdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    flush_pend_d = flush_pend_q;
    fill_we      = 1'b0;
    cpu_ready    = 1'b0;
    cpu_rdata    = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req) begin
          // Offset is dropped here so the key doubles as the word-aligned fill address.
          key_d = '{
            tag:    bus.cpu_addr[31 -: TAG_W],
            index:  bus.cpu_addr[2 +: INDEX_W],
            offset: 2'b00
          };
          state_d = StLookup;
        end
      end

      StLookup: begin
        if (lookup_hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = lookup_entry.data;
          rdata_d   = lookup_entry.data;
          hit_cnt_d = hit_cnt_q + CNT_W'(1);
          state_d   = StIdle;
        end else begin
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
          mem_req_d  = 1'b1;
          mem_addr_d = key_q;
          state_d    = StFill;
        end
      end

      StFill: begin
        if (flush) begin
          flush_pend_d = 1'b1;
        end
        if (bus.mem_ack) begin
          mem_req_d   = 1'b0;
          fill_data_d = bus.mem_rdata;
          // Any flush during the fill keeps this (possibly stale) word out of the cache.
          fill_we     = !flush_pend_q && !flush;
          state_d     = StResp;
        end
      end

      StResp: begin
        cpu_ready    = 1'b1;
        cpu_rdata    = fill_data_q;
        rdata_d      = fill_data_q;
        flush_pend_d = 1'b0;
        state_d      = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (fill_we) begin
      valid_d[key_q.index] = fill_entry.isvalid;
    end
    // Flush wins over a same-cycle install and applies in every state.
    if (flush) begin
      valid_d = '0;
    end
  end

  // Control state, valid bits, fill request and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      key_q        <= '0;
      valid_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      fill_data_q  <= '0;
      rdata_q      <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      valid_q      <= valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      fill_data_q  <= fill_data_d;
      rdata_q      <= rdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Tag/data array write on an accepted fill.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[key_q.index]  <= fill_entry.tag;
      data_mem[key_q.index] <= fill_entry.data;
    end
  end

  assign bus.cpu_ready = cpu_ready;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.busy      = (state_q != StIdle);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

endmodule

// File: doc/rv32i_rom_cache_ctrl.md
Name: rv32i_rom_cache_ctrl

Overview:
Direct-mapped, read-only instruction cache controller between the rv32i fetch stage and the instruction ROM/bridge memory.
- 32 one-word lines, using the packed cache key (25-bit tag, 5-bit index, 2-bit offset) and the packed cache entry (isvalid, tag, data) from the rv32i package.
- Serves hits from local storage and runs a single-outstanding fill FSM on misses.
- Supports a synchronous flush (e.g. after ROM reload).

Parameters:
INDEX_W, 5, index width; line count = 2**INDEX_W (matches CACHE_LENGTH).
TAG_W, 25, tag width = 32 - INDEX_W - 2.
CNT_W, 16, width of miss/hit performance counters.

Ports:
clk  in  1  system clock; all logic rising-edge.
reset_n  in  1  asynchronous active-low reset.
cpu_req  in  1  fetch request; sampled only when busy=0.
cpu_addr  in  32  fetch byte address; bits [1:0] ignored.
cpu_ready  out  1  one-cycle pulse; cpu_rdata valid this cycle.
cpu_rdata  out  32  fetched instruction word.
busy  out  1  high in every state except IDLE.
flush  in  1  invalidate all lines (single-cycle pulse or level).
mem_req  out  1  fill request to backing memory; held until mem_ack.
mem_addr  out  32  fill address = {tag,index,2'b00}.
mem_ack  in  1  backing memory data valid; single-cycle.
mem_rdata  in  32  fill data, valid with mem_ack.
hit_cnt  out  CNT_W  wrapping hit counter.
miss_cnt  out  CNT_W  wrapping miss counter.

Behaviour:
- Reset values:
  - state=IDLE; all isvalid=0; cpu_ready=0; cpu_rdata=0; mem_req=0; mem_addr=0; busy=0; counters=0; flush_pend=0.
  - Tag/data arrays are not reset.
- States: IDLE, LOOKUP, FILL, RESP.
- IDLE:
  - cpu_req=1 latches cpu_addr into key register -> LOOKUP.
- LOOKUP:
  - Read entry[index].
  - Hit (isvalid && tag match): cpu_ready=1, cpu_rdata=entry.data, hit_cnt++, -> IDLE. Hit latency is 2 cycles from the request edge.
  - Miss: miss_cnt++, mem_req=1, mem_addr={tag,index,2'b00}, -> FILL.
- FILL:
  - mem_req and mem_addr stay stable until mem_ack.
  - On mem_ack: mem_req=0 next cycle, capture mem_rdata, -> RESP.
  - Entry write: {1,tag,mem_rdata}, unless flush_pend or flush is set.
  - No timeout.
- RESP:
  - cpu_ready=1, cpu_rdata=captured fill word; clear flush_pend; -> IDLE.
- cpu_ready is high for exactly one cycle per accepted request. cpu_rdata holds its last value otherwise.
- cpu_req while busy=1 is ignored (not queued). The requester must hold or re-issue it.
- Flush:
  - Clears every isvalid in the cycle it is sampled, in any state.
  - flush in IDLE together with cpu_req: the invalidate and the request acceptance both occur. The request then misses.
  - flush in LOOKUP: the invalidate takes priority. That lookup is treated as a miss.
  - flush in FILL, or in the mem_ack cycle: sets flush_pend. The fill completes and the word is returned to the CPU, but the line is not installed.
- Index aliasing: addresses differing only in tag (e.g. 0x0000_0000 vs 0x0000_0080) share a line; a fill overwrites the entry.
- Asynchronous reset mid-FILL:
  - Aborts immediately; mem_req=0.
  - Backing memory must tolerate an abandoned request; a later stray mem_ack in IDLE is ignored.
- Counters wrap modulo 2**CNT_W and are not affected by flush.

Test Plan:
- Cold miss: reset, cpu_req addr 0x0000_0010, mem_ack 3 cycles after mem_req with 0xDEAD_BEEF -> mem_addr=0x0000_0010; cpu_ready one cycle after mem_ack with 0xDEAD_BEEF; miss_cnt=1.
- Hit: repeat addr 0x0000_0012 -> no mem_req; cpu_ready at LOOKUP with 0xDEAD_BEEF; hit_cnt=1.
- Conflict: fill 0x0000_0000 (0x1111_1111), then 0x0000_0080 (0x2222_2222), then 0x0000_0000 -> third access misses and refetches; miss_cnt=3.
- Flush: after a hit-warm line, pulse flush, re-request the same addr -> miss with mem_req; flush concurrent with cpu_req in IDLE -> also a miss.
- Flush during FILL: flush 1 cycle after mem_req, ack with 0xCAFE_0001 -> CPU gets 0xCAFE_0001; next access to the same addr misses.
- Reset mid-FILL: drop reset_n while mem_req=1 -> mem_req=0 asynchronously, busy=0; later mem_ack ignored; next request misses normally.
